// File: rtl/clock_set_ctrl_if.sv
// Key pulses into, and display fields out of, clock_set_ctrl.
interface clock_set_ctrl_if;
  logic       key_mode;
  logic       key_inc;
  logic       key_dec;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [5:0] blank;
  logic [1:0] mode;
  logic       tick_1s;

  modport master (
    output key_mode, key_inc, key_dec,
    input  hour, min, sec, blank, mode, tick_1s
  );

  modport slave (
    input  key_mode, key_inc, key_dec,
    output hour, min, sec, blank, mode, tick_1s
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-keeping / time-setting controller for the segment-display clock.
// Define CLOCK_PRESET_EN to reset to INIT_HOUR:INIT_MIN:INIT_SEC instead of 00:00:00.
module clock_set_ctrl #(
  parameter int unsigned CNT_1S    = 50_000_000,
  parameter int unsigned BLINK_CNT = 12_500_000,
  parameter int unsigned INIT_HOUR = 22,
  parameter int unsigned INIT_MIN  = 46,
  parameter int unsigned INIT_SEC  = 40
) (
  input logic           clk,
  input logic           rstn,
  clock_set_ctrl_if.slave io
);

  localparam int unsigned PW = $clog2(CNT_1S);
  localparam int unsigned BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CNT_1S - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

`ifdef CLOCK_PRESET_EN
  localparam bit PRESET = 1'b1;
`else
  localparam bit PRESET = 1'b0;
`endif
  localparam logic [4:0] RST_HOUR = PRESET ? 5'(INIT_HOUR) : '0;
  localparam logic [5:0] RST_MIN  = PRESET ? 6'(INIT_MIN)  : '0;
  localparam logic [5:0] RST_SEC  = PRESET ? 6'(INIT_SEC)  : '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [4:0]      hour_q, hour_n;
  logic [5:0]      min_q, min_n, sec_q, sec_n;
  logic [PW-1:0]   presc_q, presc_n;
  logic [BW-1:0]   bcnt_q, bcnt_n;
  logic            bph_q, bph_n;
  logic [5:0]      blank_q, blank_n;
  logic            tick_q, tick_n;
  logic            adj;

  // Out-of-range values (>= last) go to 0 on increment.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] last);
    return (v >= last) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_wrap(input logic [5:0] v, input logic [5:0] last);
    return (v == 6'd0) ? last : v - 6'd1;
  endfunction

  always_comb begin
    state_n = state;
    hour_n  = hour_q;
    min_n   = min_q;
    sec_n   = sec_q;
    presc_n = '0;
    tick_n  = 1'b0;
    bcnt_n  = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + BW'(1);
    bph_n   = bph_q ^ (bcnt_q == BLINK_LAST);
    // key_mode wins over inc/dec; both inc and dec together cancel.
    adj     = (io.key_inc ^ io.key_dec) & ~io.key_mode;

    if (io.key_mode) begin
      bcnt_n = '0;
      bph_n  = 1'b0;
      case (state)
        RUN:      state_n = SET_HOUR;
        SET_HOUR: state_n = SET_MIN;
        SET_MIN:  state_n = SET_SEC;
        default:  state_n = RUN;
      endcase
    end

    case (state)
      RUN: begin
        if (presc_q == PRESC_LAST) begin
          tick_n = 1'b1;
          sec_n  = inc_wrap(sec_q, 6'd59);
          if (sec_q >= 6'd59) begin
            min_n = inc_wrap(min_q, 6'd59);
            if (min_q >= 6'd59)
              hour_n = 5'(inc_wrap({1'b0, hour_q}, 6'd23));
          end
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
      SET_HOUR: if (adj)
        hour_n = io.key_inc ? 5'(inc_wrap({1'b0, hour_q}, 6'd23))
                            : 5'(dec_wrap({1'b0, hour_q}, 6'd23));
      SET_MIN: if (adj)
        min_n = io.key_inc ? inc_wrap(min_q, 6'd59) : dec_wrap(min_q, 6'd59);
      default: if (adj)
        sec_n = io.key_inc ? inc_wrap(sec_q, 6'd59) : dec_wrap(sec_q, 6'd59);
    endcase

    case (state_n)
      SET_HOUR: blank_n = {{2{bph_n}}, 4'b0000};
      SET_MIN:  blank_n = {2'b00, {2{bph_n}}, 2'b00};
      SET_SEC:  blank_n = {4'b0000, {2{bph_n}}};
      default:  blank_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RUN;
      hour_q  <= RST_HOUR;
      min_q   <= RST_MIN;
      sec_q   <= RST_SEC;
      presc_q <= '0;
      bcnt_q  <= '0;
      bph_q   <= 1'b0;
      blank_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state   <= state_n;
      hour_q  <= hour_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
      presc_q <= presc_n;
      bcnt_q  <= bcnt_n;
      bph_q   <= bph_n;
      blank_q <= blank_n;
      tick_q  <= tick_n;
    end
  end

  assign io.hour    = hour_q;
  assign io.min     = min_q;
  assign io.sec     = sec_q;
  assign io.blank   = blank_q;
  assign io.mode    = state;
  assign io.tick_1s = tick_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (CNT_1S=10, BLINK_CNT=4).
module tb_clock_set_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  clock_set_ctrl_if io ();

  clock_set_ctrl #(
    .CNT_1S   (10),
    .BLINK_CNT(4),
    .INIT_HOUR(22),
    .INIT_MIN (46),
    .INIT_SEC (40)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .io  (io)
  );

  always #5 clk = ~clk;

`ifdef CLOCK_PRESET_EN
  localparam int unsigned H0 = 22, M0 = 46, S0 = 40;
  localparam int unsigned H60 = 22, M60 = 47, S60 = 40;
`else
  localparam int unsigned H0 = 0, M0 = 0, S0 = 0;
  localparam int unsigned H60 = 0, M60 = 1, S60 = 0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Key sampled at the posedge between the two negedges; result visible on return.
  task automatic pulse(input logic m, input logic i, input logic d);
    @(negedge clk);
    io.key_mode = m; io.key_inc = i; io.key_dec = d;
    @(negedge clk);
    io.key_mode = 1'b0; io.key_inc = 1'b0; io.key_dec = 1'b0;
  endtask

  task automatic wait_tick(output int unsigned n);
    n = 999;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (io.tick_1s) begin
        n = k;
        return;
      end
    end
  endtask

  function automatic int unsigned field(input int sel);
    case (sel)
      0:       return io.hour;
      1:       return io.min;
      default: return io.sec;
    endcase
  endfunction

  task automatic set_field(input string tag, input int sel, input int unsigned target);
    for (int k = 0; k < 64 && field(sel) != target; k++) pulse(1'b0, 1'b1, 1'b0);
    check(tag, field(sel), target);
  endtask

  initial begin
    int unsigned n;
    logic        seen;
    logic [5:0]  exp_blank;

    io.key_mode = 1'b0; io.key_inc = 1'b0; io.key_dec = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hour", io.hour, H0);
    check("rst_min", io.min, M0);
    check("rst_sec", io.sec, S0);
    check("rst_mode", io.mode, 0);
    check("rst_blank", io.blank, 0);
    check("rst_tick", io.tick_1s, 0);

    // 600 cycles of RUN: 60 ticks, period 10, each one cycle wide.
    rstn = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      wait_tick(n);
      check("tick_period", n, 10);
      check("run_sec", io.sec, (S0 + t) % 60);
    end
    check("run_min", io.min, M60);
    check("run_hour", io.hour, H60);
    @(negedge clk);
    check("tick_width", io.tick_1s, 0);

    // SET_HOUR: reach 0, then decrement wraps to 23.
    pulse(1'b1, 1'b0, 1'b0);
    check("mode_set_hour", io.mode, 1);
    set_field("hour_to_0", 0, 0);
    pulse(1'b0, 1'b0, 1'b1);
    check("hour_dec_wrap", io.hour, 23);
    check("frozen_min", io.min, M60);
    check("frozen_sec", io.sec, S60);
    check("set_no_tick", io.tick_1s, 0);

    // key_mode together with key_inc: mode advances, hour untouched.
    pulse(1'b1, 1'b1, 1'b0);
    check("mode_inc_mode", io.mode, 2);
    check("mode_inc_hour", io.hour, 23);

    // Blink in SET_MIN: starts visible, toggles every 4 cycles.
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      exp_blank = ((k / 4) % 2 == 1) ? 6'b001100 : 6'b000000;
      check("blink_min", io.blank, exp_blank);
    end

    pulse(1'b0, 1'b1, 1'b1);
    check("inc_dec_min", io.min, M60);
    for (int k = 0; k < 60; k++) pulse(1'b0, 1'b1, 1'b0);
    check("inc60_min", io.min, M60);
    check("inc60_hour", io.hour, 23);
    set_field("min_to_59", 1, 59);

    pulse(1'b1, 1'b0, 1'b0);
    check("mode_set_sec", io.mode, 3);
    set_field("sec_to_59", 2, 59);
    pulse(1'b1, 1'b0, 1'b0);
    check("mode_run", io.mode, 0);
    check("pre_wrap_hour", io.hour, 23);
    check("pre_wrap_min", io.min, 59);
    check("pre_wrap_sec", io.sec, 59);

    // Day wrap: exactly 10 cycles after leaving SET_SEC.
    wait_tick(n);
    check("exit_tick_delay", n, 10);
    check("wrap_hour", io.hour, 0);
    check("wrap_min", io.min, 0);
    check("wrap_sec", io.sec, 0);

    pulse(1'b0, 1'b1, 1'b0);
    check("run_ignores_inc", io.sec, 0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | io.tick_1s | (|io.blank);
    end
    check("run_single_tick_no_blank", seen, 0);

    // Asynchronous reset while in SET_SEC.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check("mode_set_sec2", io.mode, 3);
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_mode", io.mode, 0);
    check("midrst_hour", io.hour, H0);
    check("midrst_min", io.min, M0);
    check("midrst_sec", io.sec, S0);
    check("midrst_blank", io.blank, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_tick(n);
    check("rst_first_tick", n, 10);
    check("rst_first_sec", io.sec, (S0 + 1) % 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-keeping and time-setting controller for the segment-display clock. It owns the hour/minute/second registers and advances them on a 1 s tick. A two-key mode FSM lets the user select and adjust one field at a time. It drives the `hour`/`min`/`sec` inputs of the display driver, plus a per-digit blank mask that makes the field being set blink.

## Interface
- `CNT_1S`, 50_000_000: clk cycles per second tick (≥2).
- `BLINK_CNT`, 12_500_000: clk cycles per blink half-period (≥1).
- `INIT_HOUR`, 22: reset hour when preset is compiled in (0–23).
- `INIT_MIN`, 46: reset minute when preset is compiled in (0–59).
- `INIT_SEC`, 40: reset second when preset is compiled in (0–59).

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset; asynchronous, active-low.
- `key_mode` in 1: debounced single-cycle pulse; advances the mode.
- `key_inc` in 1: debounced single-cycle pulse; increments the selected field.
- `key_dec` in 1: debounced single-cycle pulse; decrements the selected field.
- `hour` out 5: current hour, 0–23.
- `min` out 6: current minute, 0–59.
- `sec` out 6: current second, 0–59.
- `blank` out 6: digit blank mask. Bit order is {hour_hi, hour_lo, min_hi, min_lo, sec_hi, sec_lo}; 1 = blank.
- `mode` out 2: FSM state encoding. 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN, 3 = SET_SEC.
- `tick_1s` out 1: one-cycle pulse on each second advance.

## Operation
- **Reset values:**
  - `hour`/`min`/`sec` = 0/0/0 (see Configuration).
  - `mode` = RUN, `blank` = 0, `tick_1s` = 0.
  - Prescaler = 0, blink counter = 0, blink phase = 0.
- **FSM:**
  - RUN → SET_HOUR → SET_MIN → SET_SEC → RUN; each transition on a `key_mode` pulse.
  - There are no other transitions.
- **RUN:**
  - The prescaler counts 0..CNT_1S-1 and then wraps.
  - On the wrap cycle, `tick_1s`=1 and `sec` increments.
  - `sec` 59→0 carries into `min`; `min` 59→0 carries into `hour`; `hour` 23→0.
  - 23:59:59 → 00:00:00 in one tick.
  - `key_inc`/`key_dec` are ignored.
- **SET_x states:**
  - The prescaler is held at 0, `tick_1s`=0, and the time is frozen.
  - `key_inc` adds 1 to the selected field only, modulo its range (hour 23→0, min/sec 59→0). There is no carry into other fields.
  - `key_dec` subtracts 1 modulo range (0→23 or 0→59), also without carry.
- **Simultaneous keys:**
  - `key_inc` and `key_dec` in the same cycle: no change.
  - `key_mode` together with inc/dec: the mode advances and inc/dec is discarded; the field is not modified.
- **Blink:**
  - The blink counter runs 0..BLINK_CNT-1 in all states and toggles the blink phase on wrap.
  - In a SET state, the two `blank` bits of the selected field equal the blink phase; all other bits are 0.
  - In RUN, `blank`=0.
  - On any `key_mode` pulse, the blink counter and phase clear to 0, so a newly selected field starts visible.
- **Exit to RUN:** the prescaler restarts from 0. The first tick after SET_SEC→RUN occurs exactly CNT_1S cycles later.
- All arithmetic uses field width. Out-of-range values are unreachable; if present (e.g., an illegal INIT_x), the next increment forces the field to 0.

## Timing
- All outputs are registered. There is no combinational path from keys to outputs.
- A key pulse sampled at edge N is visible on `hour`/`min`/`sec`/`mode`/`blank` after edge N, i.e. one cycle of latency.
- `tick_1s` is asserted in the same cycle the incremented time appears on the outputs.
- Tick period in RUN is exactly CNT_1S cycles.
- Blink half-period is exactly BLINK_CNT cycles.
- `rstn` assertion mid-operation (in any state, mid-count) immediately forces reset values; there is no pending key or tick after release.
- The first tick after `rstn` deassertion occurs CNT_1S cycles after the first active edge.

## Configuration
- `CLOCK_PRESET_EN`:
  - When defined, reset loads `hour`/`min`/`sec` = INIT_HOUR/INIT_MIN/INIT_SEC (default 22:46:40).
  - When undefined, reset loads 00:00:00 and the INIT_x parameters are unused.
  - All other behaviour is identical.

## Test plan
All scenarios use CNT_1S=10 and BLINK_CNT=4.
- **Reset then run:** 600 cycles in RUN → `sec`=0..59, then `min`=1, `sec`=0; `tick_1s` every 10 cycles, each exactly 1 cycle wide.
- **Day wrap:** preset 23:59:59 via set keys, return to RUN, wait 10 cycles → 00:00:00 with a single `tick_1s`.
- **Field wrap:**
  - SET_HOUR, `key_dec` at 0 → `hour`=23.
  - SET_MIN, `key_inc` ×60 → `min` back to original, `hour` unchanged.
- **Simultaneous keys:**
  - `key_inc`+`key_dec` same cycle → no change.
  - `key_mode`+`key_inc` same cycle in SET_HOUR → `mode`=2, `hour` unchanged.
- **Blink:** in SET_MIN, `blank` toggles between 6'b000000 and 6'b001100 every 4 cycles; in RUN it stays 0.
- **Reset mid-set and preset:**
  - Assert `rstn` in SET_SEC → `mode`=0; time returns to 00:00:00, or 22:46:40 with `CLOCK_PRESET_EN`.
  - The first tick occurs 10 cycles after release.
